// File: rtl/m2_vend_pkg.sv
// Shared types and helpers for the m2_moore_vend token/coin sequencer.
package m2_vend_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    VEND  = 2'd2,
    ABORT = 2'd3
  } vend_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Single-cycle rising-edge detector; the history register is cleared by reset so a level
// already high when reset releases yields one pulse.
module edge_rise (
  input  logic clk,
  input  logic R,
  input  logic d,
  output logic q_pulse
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (R) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign q_pulse = d & ~d_q;

endmodule

// File: rtl/m2_moore_vend.sv
// Moore token/coin vend sequencer: token arms a session, N_COINS coins vend, coin
// inactivity aborts; VEND/ABORT return to IDLE after HOLD cycles (HOLD=0 holds until R).
module m2_moore_vend
  import m2_vend_pkg::*;
#(
  parameter int unsigned N_COINS = 2,
  parameter int unsigned CW      = $clog2(N_COINS + 1),
  parameter int unsigned TIMEOUT = 100_000_000,
  parameter int unsigned HOLD    = 50_000_000,
  parameter int unsigned TW      = $clog2(max_u(TIMEOUT, HOLD) + 1)
) (
  input  logic          clk,
  input  logic          R,
  input  logic          iT,
  input  logic          iM,
  output logic          T,
  output logic          V,
  output logic [CW-1:0] D,
  output logic          E
);

  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] HoldLast    = TW'((HOLD == 0) ? 0 : HOLD - 1);
  localparam logic [CW-1:0] CoinsLast   = CW'(N_COINS - 1);
  localparam logic [CW-1:0] CoinsFull   = CW'(N_COINS);
  localparam bit            HoldTimed   = (HOLD != 0);

  vend_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          t_rise, m_rise;

  edge_rise u_edge_t (
    .clk     (clk),
    .R       (R),
    .d       (iT),
    .q_pulse (t_rise)
  );

  edge_rise u_edge_m (
    .clk     (clk),
    .R       (R),
    .d       (iM),
    .q_pulse (m_rise)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        timer_d = '0;
        if (t_rise) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        // A coin on the timeout cycle takes priority over the abort.
        if (m_rise) begin
          cnt_d   = cnt_q + 1'b1;
          timer_d = '0;
          if (cnt_q == CoinsLast) begin
            state_d = VEND;
          end
        end else if (timer_q == TimeoutLast) begin
          state_d = ABORT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      VEND, ABORT: begin
        if (HoldTimed) begin
          if (timer_q == HoldLast) begin
            state_d = IDLE;
            cnt_d   = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    T = 1'b0;
    V = 1'b0;
    D = '0;
    E = 1'b0;
    case (state_q)
      ARMED: begin
        T = 1'b1;
        D = cnt_q;
      end
      VEND: begin
        T = 1'b1;
        V = 1'b1;
        D = CoinsFull;
      end
      ABORT: begin
        E = 1'b1;
        D = cnt_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_m2_moore_vend.sv
// Bench for m2_moore_vend: one DUT with timed hold, one with hold-until-reset, both fed
// the same stimulus and compared against a cycle-level session model.
module tb_m2_moore_vend;

  localparam int N  = 3;
  localparam int TO = 8;
  localparam int HA = 4;
  localparam int HB = 0;

  localparam int PhIdle  = 0;
  localparam int PhSess  = 1;
  localparam int PhVend  = 2;
  localparam int PhAbort = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic R = 1'b1, iT = 1'b0, iM = 1'b0;
  logic t_a, v_a, e_a, t_b, v_b, e_b;
  logic [1:0] d_a, d_b;

  m2_moore_vend #(.N_COINS(N), .TIMEOUT(TO), .HOLD(HA)) dut_a (
    .clk (clk), .R (R), .iT (iT), .iM (iM), .T (t_a), .V (v_a), .D (d_a), .E (e_a)
  );

  m2_moore_vend #(.N_COINS(N), .TIMEOUT(TO), .HOLD(HB)) dut_b (
    .clk (clk), .R (R), .iT (iT), .iM (iM), .T (t_b), .V (v_b), .D (d_b), .E (e_b)
  );

  // Session model: age counts cycles since the last event in the current phase.
  typedef struct {
    int ph;
    int coins;
    int age;
    bit pt;
    bit pm;
  } mdl_t;

  typedef struct {
    bit r;
    bit t;
    bit m;
    int exp;
  } vec_t;

  mdl_t ma = '{PhIdle, 0, 0, 1'b0, 1'b0};
  mdl_t mb = '{PhIdle, 0, 0, 1'b0, 1'b0};
  vec_t tbl [16];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic mdl_t step(mdl_t s, int hold, bit r, bit t, bit m);
    mdl_t n;
    bit te, me;
    n = s;
    if (r) begin
      n = '{PhIdle, 0, 0, 1'b0, 1'b0};
      return n;
    end
    te   = t && !s.pt;
    me   = m && !s.pm;
    n.pt = t;
    n.pm = m;
    case (s.ph)
      PhIdle: if (te) begin
        n.ph = PhSess; n.coins = 0; n.age = 0;
      end
      PhSess: begin
        if (me) begin
          n.coins = s.coins + 1;
          n.age   = 0;
          if (n.coins == N) n.ph = PhVend;
        end else begin
          n.age = s.age + 1;
          if (n.age == TO) begin
            n.ph = PhAbort; n.age = 0;
          end
        end
      end
      default: if (hold > 0) begin
        n.age = s.age + 1;
        if (n.age == hold) begin
          n.ph = PhIdle; n.coins = 0; n.age = 0;
        end
      end
    endcase
    return n;
  endfunction

  // Outputs packed as decimal digits T V E D for readable messages.
  function automatic int expo(mdl_t s);
    case (s.ph)
      PhSess:  return 1000 + s.coins;
      PhVend:  return 1100 + N;
      PhAbort: return 10 + s.coins;
      default: return 0;
    endcase
  endfunction

  function automatic int pk(logic t, logic v, logic e, logic [1:0] d);
    return 1000 * int'(t) + 100 * int'(v) + 10 * int'(e) + int'(d);
  endfunction

  task automatic tick(input bit r, input bit t, input bit m);
    R  = r;
    iT = t;
    iM = m;
    @(posedge clk);
    ma = step(ma, HA, r, t, m);
    mb = step(mb, HB, r, t, m);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got TVED=%0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".a"}, pk(t_a, v_a, e_a, d_a), expo(ma));
    chk({nm, ".b"}, pk(t_b, v_b, e_b, d_b), expo(mb));
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1000};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1000};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1001};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1001};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1002};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1002};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1103};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1103};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1103};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1103};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 0};

    // Reset, coin without token, normal vend with timed hold.
    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].r, tbl[i].t, tbl[i].m);
      chk($sformatf("vec%0d", i), pk(t_a, v_a, e_a, d_a), tbl[i].exp);
    end

    // Held levels: one token, one coin, then timeout into ABORT.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    chk("held.token", pk(t_a, v_a, e_a, d_a), 1000);
    for (int k = 1; k <= 20; k++) begin
      tick(1'b0, 1'b1, 1'b1);
      chk_model($sformatf("held%0d", k));
      if (k == 1 || k == 8) chk($sformatf("held.c%0d", k), pk(t_a, v_a, e_a, d_a), 1001);
      if (k == 9 || k == 12) chk($sformatf("held.e%0d", k), pk(t_a, v_a, e_a, d_a), 11);
      if (k == 13 || k == 20) chk($sformatf("held.i%0d", k), pk(t_a, v_a, e_a, d_a), 0);
    end
    tick(1'b0, 1'b0, 1'b0);

    // Coin arriving on the exact timeout cycle.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) tick(1'b0, 1'b0, 1'b0);
    chk("race.pre", pk(t_a, v_a, e_a, d_a), 1000);
    tick(1'b0, 1'b0, 1'b1);
    chk("race.coin", pk(t_a, v_a, e_a, d_a), 1001);
    for (int k = 1; k <= 12; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      chk_model($sformatf("race%0d", k));
      if (k == 7) chk("race.k7", pk(t_a, v_a, e_a, d_a), 1001);
      if (k == 8 || k == 11) chk($sformatf("race.e%0d", k), pk(t_a, v_a, e_a, d_a), 11);
      if (k == 12) chk("race.idle", pk(t_a, v_a, e_a, d_a), 0);
    end

    // Reset in ARMED with two coins, then in VEND.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    chk("rst.d2", pk(t_a, v_a, e_a, d_a), 1002);
    tick(1'b1, 1'b0, 1'b1);
    chk("rst.armed", pk(t_a, v_a, e_a, d_a), 0);
    tick(1'b0, 1'b1, 1'b0);
    chk("rst.retoken", pk(t_a, v_a, e_a, d_a), 1000);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
    end
    chk("rst.vend", pk(t_a, v_a, e_a, d_a), 1103);
    tick(1'b1, 1'b0, 1'b0);
    chk("rst.vend.a", pk(t_a, v_a, e_a, d_a), 0);
    chk("rst.vend.b", pk(t_b, v_b, e_b, d_b), 0);
    tick(1'b0, 1'b1, 1'b0);
    chk("rst.newsess", pk(t_a, v_a, e_a, d_a), 1000);

    // HOLD=0 keeps vending until reset.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 100; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      chk($sformatf("hold0.%0d", k), pk(t_b, v_b, e_b, d_b), 1103);
    end
    tick(1'b1, 1'b0, 1'b0);
    chk("hold0.rst", pk(t_b, v_b, e_b, d_b), 0);
    chk_model("hold0.model");

    // Random stimulus against the model.
    tick(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      bit r, t, m;
      r = ($urandom_range(0, 149) == 0);
      t = ($urandom_range(0, 5) == 0) ? ~iT : iT;
      m = ($urandom_range(0, 2) == 0) ? ~iM : iM;
      tick(r, t, m);
      chk_model($sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/m2_moore_vend.md
Name: m2_moore_vend

Overview:
- Parametrised successor to the first-generation token/coin Moore sequencer for the Basys3 FSM series.
- Accepts one token (iT), then collects N_COINS coins (iM), then asserts vend (V).
- Adds rising-edge qualification of inputs, a configurable coin count, an inactivity timeout with an abort/refund state, and timed auto-return to idle.
- Sits between the debounced button/switch front end and the LED/7-segment display logic.

Parameters:
- N_COINS, 2: coins required after the token to vend; legal range 1..15.
- CW, $clog2(N_COINS+1): width of the coin count output D. Derived; do not override.
- TIMEOUT, 100_000_000: cycles of coin inactivity in ARMED before abort (1 s at 100 MHz); must be >= 2.
- HOLD, 50_000_000: cycles spent in VEND or ABORT before returning to IDLE. 0 = hold until R.
- TW, $clog2(max(TIMEOUT,HOLD)+1): width of the shared timer. Derived.

Ports:
- clk, input, 1: system clock, rising edge.
- R, input, 1: reset, synchronous, active-high.
- iT, input, 1: token level. Already synchronised and debounced upstream.
- iM, input, 1: coin level. Already synchronised and debounced upstream.
- T, output, 1: token accepted / session active.
- V, output, 1: vend.
- D, output, CW: coins counted (in ABORT: coins to refund).
- E, output, 1: abort/timeout indicator.

Behaviour:
- Reset: R high at a posedge forces the following; R overrides every other event, including mid-VEND and mid-ABORT.
  - state=IDLE, cnt=0, timer=0
  - iT_q=0, iM_q=0
  - outputs T=0, V=0, D=0, E=0
- Edge detect:
  - tRise = iT & ~iT_q; mRise = iM & ~iM_q.
  - iT_q and iM_q register iT and iM every cycle.
  - A level held high produces exactly one event.
  - A level already high when R deasserts produces one event on the first cycle after reset (edge registers are cleared).
- Moore outputs are decoded only from the state and cnt registers.
  - Latency from an input edge to an output change: 1 clock (the posedge that first samples the input high updates the state).
- IDLE:
  - Outputs T=0, V=0, D=0, E=0.
  - tRise -> ARMED, cnt=0, timer=0.
  - mRise ignored (no coin accepted without a token).
- ARMED:
  - Outputs T=1, V=0, D=cnt, E=0.
  - mRise: cnt += 1 and timer=0. If cnt+1 == N_COINS -> VEND and timer=0.
  - No mRise: timer += 1. When timer == TIMEOUT-1 -> ABORT and timer=0.
  - mRise on the timeout cycle: the coin wins (counted, timer cleared, no abort).
  - tRise ignored.
- VEND:
  - Outputs T=1, V=1, D=N_COINS, E=0.
  - All inputs ignored.
  - HOLD>0: timer counts; at timer == HOLD-1 -> IDLE, cnt=0.
  - HOLD==0: stay in VEND until R (first-generation behaviour).
- ABORT:
  - Outputs T=0, V=0, D=cnt (refund count, frozen), E=1.
  - All inputs ignored.
  - Exit rules are identical to VEND; cnt is cleared on exit.
- Timeout with cnt=0 is legal: ABORT with D=0.
- Arithmetic:
  - cnt never exceeds N_COINS; no wrap is possible.
  - The timer saturates logically because it is cleared on every state transition.
- Unreachable/illegal state encodings recover to IDLE on the next clock.

Decomposition:
- Package m2_vend_pkg holds typedef enum logic [1:0] {IDLE, ARMED, VEND, ABORT} vend_state_t.
- One sub-module, edge_rise: clk, R, d -> q_pulse. Instantiated twice, for iT and iM.
- Timer, counter and FSM live in the top module.

Test Plan:
All scenarios use N_COINS=3, TIMEOUT=8, HOLD=4.
- Reset and idle:
  - Stimulus: R=1 for 2 clocks, then pulse iM with no token.
  - Required: T=0, V=0, D=0, E=0 throughout; state stays IDLE.
- Normal vend:
  - Stimulus: iT rise; then 3 separate iM rises spaced 2 clocks apart.
  - Required: T=1 one clock after iT; D steps 0->1->2; V=1 with D=3 one clock after the third coin; V held exactly 4 clocks; then all outputs 0.
- Held level:
  - Stimulus: iT high and iM high continuously for 20 clocks after the token.
  - Required: exactly one coin counted (D=1); iT ignored after the first event; ABORT once 8 idle cycles expire, E=1 with D=1.
- Timeout race:
  - Stimulus: after the token, wait 7 clocks, then an iM rise on the exact timeout cycle.
  - Required: D=1, E stays 0, timer restarts.
  - Follow-up: 8 further idle clocks -> E=1, D=1, for 4 clocks, then IDLE.
- Reset mid-operation:
  - Stimulus: assert R during ARMED (D=2), and separately during VEND.
  - Required: outputs all 0 on the next clock; a subsequent token starts with D=0.
- Hold-forever mode:
  - Stimulus: HOLD=0, complete a vend, wait 100 clocks, then R.
  - Required: V=1 and D=3 persist until R; all outputs 0 one clock after R.
